// File: rtl/hicore_alu_iq_pkg.sv
// hicore_alu_iq_pkg: shared HiCore widths and operand-slot type for the ALU issue queue
`ifndef HiCore_REG_SIZE
`define HiCore_REG_SIZE 32
`endif
`ifndef HiCore_ROB_PTR_SIZE
`define HiCore_ROB_PTR_SIZE 5
`endif
`ifndef HiCore_ISSUE2ALU_SIZE
`define HiCore_ISSUE2ALU_SIZE 10
`endif
`ifndef HiCore_ALU_CTRL_SIZE
`define HiCore_ALU_CTRL_SIZE 7
`endif
package hicore_alu_iq_pkg;
  localparam int REG_W = `HiCore_REG_SIZE;
  localparam int PTR_W = `HiCore_ROB_PTR_SIZE;
  localparam int INFO_SIZE = `HiCore_ISSUE2ALU_SIZE;
  localparam int CTRL_W = `HiCore_ALU_CTRL_SIZE;
  typedef struct packed {
    logic rdy;
    logic [PTR_W-1:0] ptr;
    logic [REG_W-1:0] val;
  } src_t;
  function automatic src_t src_wake(input src_t s, input logic hit, input logic [REG_W-1:0] d);
    src_t r;
    r = s;
    if (!s.rdy && hit) begin
      r.rdy = 1'b1;
      r.val = d;
    end
    return r;
  endfunction
endpackage

// File: rtl/hicore_alu_iq_wakeup.sv
// hicore_iq_wakeup: matches one operand's producer ptr against all writeback ports; lowest port wins
module hicore_iq_wakeup import hicore_alu_iq_pkg::*; #(
  parameter int NUM_WB = 2
) (
  input  logic [PTR_W-1:0]        ptr,
  input  logic [NUM_WB-1:0]       wb_wen,
  input  logic [NUM_WB*PTR_W-1:0] wb_ptr,
  input  logic [NUM_WB*REG_W-1:0] wb_data,
  output logic                    hit,
  output logic [REG_W-1:0]        data
);
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int k = NUM_WB - 1; k >= 0; k--)
      if (wb_wen[k] && wb_ptr[k*PTR_W +: PTR_W] == ptr) begin
        hit = 1'b1;
        data = wb_data[k*REG_W +: REG_W];
      end
  end
endmodule

// File: rtl/hicore_alu_iq.sv
// hicore_alu_iq: age-ordered compacting ALU issue queue with writeback wakeup; HICORE_IQ_WAKEUP_BYPASS_EN enables same-cycle wakeup-to-issue
module hicore_alu_iq import hicore_alu_iq_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int NUM_WB = 2,
  parameter int INFO_W = INFO_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [REG_W-1:0]           disp_src1,
  input  logic                       disp_src1_rdy,
  input  logic [PTR_W-1:0]           disp_src1_ptr,
  input  logic [REG_W-1:0]           disp_src2,
  input  logic                       disp_src2_rdy,
  input  logic [PTR_W-1:0]           disp_src2_ptr,
  input  logic [CTRL_W-1:0]          disp_ctrl,
  input  logic [INFO_W-1:0]          disp_info,
  input  logic [NUM_WB-1:0]          wb_wen,
  input  logic [NUM_WB*PTR_W-1:0]    wb_ptr,
  input  logic [NUM_WB*REG_W-1:0]    wb_data,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic                       iss_cancel,
  output logic [REG_W-1:0]           iss_src1,
  output logic [REG_W-1:0]           iss_src2,
  output logic [CTRL_W-1:0]          iss_ctrl,
  output logic [INFO_W-1:0]          iss_info,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] iq_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  src_t s1_q [DEPTH];
  src_t s2_q [DEPTH];
  src_t s1_w [DEPTH];
  src_t s2_w [DEPTH];
  src_t s1_n [DEPTH];
  src_t s2_n [DEPTH];
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_n [DEPTH];
  logic [INFO_W-1:0] info_q [DEPTH];
  logic [INFO_W-1:0] info_n [DEPTH];
  logic [REG_W-1:0] d1 [DEPTH];
  logic [REG_W-1:0] d2 [DEPTH];
  logic [DEPTH-1:0] rdy, h1, h2;
  logic [CW-1:0] cnt, wp;
  logic [IW-1:0] sel;
  logic [REG_W-1:0] dd1, dd2;
  logic dh1, dh2, fire, acc;
  src_t ds1, ds2;
  // incoming ops snoop writeback too, so a wakeup in the dispatch cycle is not lost
  hicore_iq_wakeup #(.NUM_WB(NUM_WB)) u_dw1 (.ptr(disp_src1_ptr), .wb_wen(wb_wen), .wb_ptr(wb_ptr), .wb_data(wb_data), .hit(dh1), .data(dd1));
  hicore_iq_wakeup #(.NUM_WB(NUM_WB)) u_dw2 (.ptr(disp_src2_ptr), .wb_wen(wb_wen), .wb_ptr(wb_ptr), .wb_data(wb_data), .hit(dh2), .data(dd2));
  assign ds1 = src_wake(src_t'{disp_src1_rdy, disp_src1_ptr, disp_src1}, dh1, dd1);
  assign ds2 = src_wake(src_t'{disp_src2_rdy, disp_src2_ptr, disp_src2}, dh2, dd2);
  assign disp_ready = cnt != CW'(DEPTH);
  assign iss_valid = |rdy;
  assign iss_cancel = flush;
  assign fire = iss_valid && iss_ready && !flush;
  assign acc = disp_valid && disp_ready && !flush;
  assign wp = cnt - CW'(fire);
  assign iq_count = cnt;
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    localparam int N = (i == DEPTH - 1) ? i : i + 1;
    logic shift, load;
    hicore_iq_wakeup #(.NUM_WB(NUM_WB)) u_w1 (.ptr(s1_q[i].ptr), .wb_wen(wb_wen), .wb_ptr(wb_ptr), .wb_data(wb_data), .hit(h1[i]), .data(d1[i]));
    hicore_iq_wakeup #(.NUM_WB(NUM_WB)) u_w2 (.ptr(s2_q[i].ptr), .wb_wen(wb_wen), .wb_ptr(wb_ptr), .wb_data(wb_data), .hit(h2[i]), .data(d2[i]));
    assign s1_w[i] = src_wake(s1_q[i], h1[i], d1[i]);
    assign s2_w[i] = src_wake(s2_q[i], h2[i], d2[i]);
`ifdef HICORE_IQ_WAKEUP_BYPASS_EN
    assign rdy[i] = CW'(i) < cnt && s1_w[i].rdy && s2_w[i].rdy;
`else
    assign rdy[i] = CW'(i) < cnt && s1_q[i].rdy && s2_q[i].rdy;
`endif
    assign shift = fire && IW'(i) >= sel;
    assign load = acc && wp == CW'(i);
    assign s1_n[i] = load ? ds1 : shift ? s1_w[N] : s1_w[i];
    assign s2_n[i] = load ? ds2 : shift ? s2_w[N] : s2_w[i];
    assign ctrl_n[i] = load ? disp_ctrl : shift ? ctrl_q[N] : ctrl_q[i];
    assign info_n[i] = load ? disp_info : shift ? info_q[N] : info_q[i];
  end
  always_comb begin
    sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (rdy[i]) sel = IW'(i);
  end
`ifdef HICORE_IQ_WAKEUP_BYPASS_EN
  assign iss_src1 = s1_w[sel].val;
  assign iss_src2 = s2_w[sel].val;
`else
  assign iss_src1 = s1_q[sel].val;
  assign iss_src2 = s2_q[sel].val;
`endif
  assign iss_ctrl = ctrl_q[sel];
  assign iss_info = info_q[sel];
  // entry payload needs no reset: occupancy is fully described by cnt
  always_ff @(posedge clk) begin
    cnt <= (rst || flush) ? '0 : cnt + CW'(acc) - CW'(fire);
    for (int i = 0; i < DEPTH; i++) begin
      s1_q[i] <= s1_n[i];
      s2_q[i] <= s2_n[i];
      ctrl_q[i] <= ctrl_n[i];
      info_q[i] <= info_n[i];
    end
  end
endmodule

// File: tb/tb_hicore_alu_iq.sv
// tb_hicore_alu_iq: directed + random stimulus against a queue-based reference model of the ALU issue queue
module tb_hicore_alu_iq;
  import hicore_alu_iq_pkg::*;
  localparam int DEPTH = 4;
  localparam int NUM_WB = 2;
  localparam int CW = $clog2(DEPTH + 1);
  logic clk = 1'b0;
  logic rst;
  logic disp_valid, disp_ready, disp_src1_rdy, disp_src2_rdy;
  logic [REG_W-1:0] disp_src1, disp_src2, iss_src1, iss_src2;
  logic [PTR_W-1:0] disp_src1_ptr, disp_src2_ptr;
  logic [CTRL_W-1:0] disp_ctrl, iss_ctrl;
  logic [INFO_SIZE-1:0] disp_info, iss_info;
  logic [NUM_WB-1:0] wb_wen;
  logic [NUM_WB*PTR_W-1:0] wb_ptr;
  logic [NUM_WB*REG_W-1:0] wb_data;
  logic iss_valid, iss_ready, iss_cancel, flush;
  logic [CW-1:0] iq_count;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic r1; logic [PTR_W-1:0] p1; logic [REG_W-1:0] v1;
    logic r2; logic [PTR_W-1:0] p2; logic [REG_W-1:0] v2;
    logic [CTRL_W-1:0] ctrl; logic [INFO_SIZE-1:0] info;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  hicore_alu_iq #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .INFO_W(INFO_SIZE)) dut (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_src1(disp_src1), .disp_src1_rdy(disp_src1_rdy), .disp_src1_ptr(disp_src1_ptr),
    .disp_src2(disp_src2), .disp_src2_rdy(disp_src2_rdy), .disp_src2_ptr(disp_src2_ptr),
    .disp_ctrl(disp_ctrl), .disp_info(disp_info), .wb_wen(wb_wen), .wb_ptr(wb_ptr), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_cancel(iss_cancel), .iss_src1(iss_src1),
    .iss_src2(iss_src2), .iss_ctrl(iss_ctrl), .iss_info(iss_info), .flush(flush), .iq_count(iq_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic wb_hit(input logic [PTR_W-1:0] p, output logic [REG_W-1:0] d);
    d = '0;
    for (int k = 0; k < NUM_WB; k++)
      if (wb_wen[k] && wb_ptr[k*PTR_W +: PTR_W] == p) begin
        d = wb_data[k*REG_W +: REG_W];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic ent_t wake(input ent_t e);
    ent_t r;
    logic [REG_W-1:0] d;
    r = e;
    if (!r.r1 && wb_hit(r.p1, d)) begin r.r1 = 1'b1; r.v1 = d; end
    if (!r.r2 && wb_hit(r.p2, d)) begin r.r2 = 1'b1; r.v2 = d; end
    return r;
  endfunction

  // compare outputs against the model for the current inputs, then advance model and clock
  task automatic cyc();
    int idx;
    ent_t e;
    logic acc;
    #1;
    idx = -1;
    for (int i = 0; i < q.size(); i++) begin
`ifdef HICORE_IQ_WAKEUP_BYPASS_EN
      e = wake(q[i]);
`else
      e = q[i];
`endif
      if (e.r1 && e.r2 && idx < 0) begin
        idx = i;
        chk("iss_src1", iss_src1, e.v1);
        chk("iss_src2", iss_src2, e.v2);
        chk("iss_ctrl", iss_ctrl, e.ctrl);
        chk("iss_info", iss_info, e.info);
      end
    end
    chk("iss_valid", iss_valid, idx >= 0);
    chk("disp_ready", disp_ready, q.size() < DEPTH);
    chk("iq_count", iq_count, q.size());
    chk("iss_cancel", iss_cancel, flush);
    acc = disp_valid && q.size() < DEPTH && !flush;
    if (flush) q.delete();
    else begin
      if (idx >= 0 && iss_ready) q.delete(idx);
      foreach (q[i]) q[i] = wake(q[i]);
      if (acc) q.push_back(wake('{disp_src1_rdy, disp_src1_ptr, disp_src1, disp_src2_rdy, disp_src2_ptr, disp_src2, disp_ctrl, disp_info}));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    wb_wen = '0;
    flush = 1'b0;
  endtask

  task automatic disp(input logic r1, input logic [PTR_W-1:0] p1, input logic [REG_W-1:0] v1,
                      input logic r2, input logic [PTR_W-1:0] p2, input logic [REG_W-1:0] v2);
    disp_valid = 1'b1;
    disp_src1_rdy = r1; disp_src1_ptr = p1; disp_src1 = v1;
    disp_src2_rdy = r2; disp_src2_ptr = p2; disp_src2 = v2;
    disp_ctrl = CTRL_W'($urandom);
    disp_info = INFO_SIZE'($urandom);
  endtask

  task automatic set_wb(input int k, input logic [PTR_W-1:0] p, input logic [REG_W-1:0] d);
    wb_wen[k] = 1'b1;
    wb_ptr[k*PTR_W +: PTR_W] = p;
    wb_data[k*REG_W +: REG_W] = d;
  endtask

  initial begin
    rst = 1'b1;
    iss_ready = 1'b0;
    wb_ptr = '0;
    wb_data = '0;
    idle();
    disp(1'b1, '0, '0, 1'b1, '0, '0);
    disp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_count", iq_count, 0);
    chk("rst_valid", iss_valid, 0);
    chk("rst_ready", disp_ready, 1);
    // basic dispatch-to-issue
    iss_ready = 1'b1;
    disp(1'b1, 0, 5, 1'b1, 0, 7);
    disp_ctrl = '0;
    cyc();
    idle();
    chk("t1_valid", iss_valid, 1);
    chk("t1_src1", iss_src1, 5);
    chk("t1_src2", iss_src2, 7);
    cyc();
    chk("t1_count", iq_count, 0);
    // younger ready op bypasses older waiting op; wakeup from port 1
    iss_ready = 1'b0;
    disp(1'b0, 3, 0, 1'b1, 0, 1);
    cyc();
    disp(1'b1, 0, 11, 1'b1, 0, 12);
    cyc();
    idle();
    iss_ready = 1'b1;
    #1 chk("t2_b_first", iss_src1, 11);
    cyc();
    set_wb(1, 3, 32'hDEAD);
`ifdef HICORE_IQ_WAKEUP_BYPASS_EN
    #1 chk("t2_byp_valid", iss_valid, 1);
    chk("t2_byp_src1", iss_src1, 32'hDEAD);
    cyc();
    idle();
`else
    #1 chk("t2_reg_valid", iss_valid, 0);
    cyc();
    idle();
    chk("t2_reg_src1", iss_src1, 32'hDEAD);
    cyc();
`endif
    chk("t2_count", iq_count, 0);
    // fill to full, extra dispatch held
    iss_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(1'b1, 0, 20 + i, 1'b1, 0, 0);
      cyc();
    end
    chk("t3_full_ready", disp_ready, 0);
    chk("t3_full_count", iq_count, DEPTH);
    disp(1'b1, 0, 99, 1'b1, 0, 99);
    cyc();
    idle();
    iss_ready = 1'b1;
    cyc();
    chk("t3_ready_after", disp_ready, 1);
    chk("t3_next_src1", iss_src1, 21);
    repeat (DEPTH - 1) cyc();
    chk("t3_drained", iq_count, 0);
    // dispatch-cycle wakeup
    disp(1'b0, 9, 0, 1'b1, 0, 2);
    set_wb(0, 9, 32'h1234);
    cyc();
    idle();
    chk("t4_valid", iss_valid, 1);
    chk("t4_src1", iss_src1, 32'h1234);
    cyc();
    // middle-entry issue compacts, new op lands behind
    iss_ready = 1'b0;
    disp(1'b0, 5, 0, 1'b1, 0, 1);
    cyc();
    disp(1'b1, 0, 2, 1'b1, 0, 3);
    cyc();
    disp(1'b0, 6, 0, 1'b1, 0, 4);
    cyc();
    iss_ready = 1'b1;
    disp(1'b1, 0, 7, 1'b1, 0, 8);
    #1 chk("t5_mid_issue", iss_src1, 2);
    cyc();
    idle();
    iss_ready = 1'b0;
    chk("t5_count", iq_count, 3);
    set_wb(0, 5, 55);
    set_wb(1, 6, 66);
    cyc();
    idle();
    iss_ready = 1'b1;
    chk("t5_order0", iss_src1, 55);
    cyc();
    chk("t5_order1", iss_src1, 66);
    cyc();
    chk("t5_order2", iss_src1, 7);
    cyc();
    // flush kills everything including same-cycle dispatch
    iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(1'b1, 0, 40 + i, 1'b1, 0, 0);
      cyc();
    end
    disp(1'b1, 0, 77, 1'b1, 0, 77);
    flush = 1'b1;
    #1 chk("t6_cancel", iss_cancel, 1);
    chk("t6_valid", iss_valid, 1);
    cyc();
    idle();
    chk("t6_count", iq_count, 0);
    chk("t6_empty", iss_valid, 0);
    cyc();
    // random traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      if ($urandom_range(0, 2) != 0)
        disp(1'($urandom_range(0, 1)), PTR_W'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), PTR_W'($urandom_range(0, 7)), $urandom);
      for (int k = 0; k < NUM_WB; k++)
        if ($urandom_range(0, 2) == 0) set_wb(k, PTR_W'($urandom_range(0, 7)), $urandom);
      if (wb_wen[0] && wb_wen[1] && wb_ptr[0 +: PTR_W] == wb_ptr[PTR_W +: PTR_W])
        wb_data[REG_W +: REG_W] = wb_data[0 +: REG_W];
      iss_ready = 1'($urandom_range(0, 3) != 0);
      flush = 1'($urandom_range(0, 24) == 0);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
